// File: rtl/ft601_pkg.sv
// ----------------------------------------------------------------------------
// ft601_pkg
// Definitions shared by the FT601 controller, the receive buffer and the top
// level: bus widths, the "all bytes valid" byte-enable pattern and the
// controller state encoding.
// ----------------------------------------------------------------------------
package ft601_pkg;

  localparam int FT601_DATA_W = 32;
  localparam int FT601_BE_W   = 4;

  localparam logic [FT601_BE_W-1:0] BE_ALL = 4'hF;

  // Controller state encoding. It lives here so that the controller, this
  // buffer and the top level all refer to one definition.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR      = 3'd5
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// Generic single-clock first-word-fall-through FIFO. The head entry is read
// combinationally from the storage array, so a word written into an empty
// FIFO becomes visible one cycle after the write.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   clear       synchronous flush of pointers and level (storage untouched)
//   wr_en       write request; accepted when not full, or full with a read
//   wr_data     word to write
//   rd_en       read request; ignored while empty
//   rd_data     head entry (0 while empty)
//   level       current occupancy
//   level_next  occupancy after this edge
//   full, empty occupancy flags
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter  int DEPTH = 16,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_next,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = wr_en && (!full || do_pop);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the level counter
  // already marks every entry invalid, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  // Gated so the head reads as 0 while nothing valid is stored.
  assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;

  a_level_bound : assert property (@(posedge clk) disable iff (rst)
    level_q <= LW'(DEPTH));

endmodule

// File: rtl/ft601_rx_buffer.sv
// ----------------------------------------------------------------------------
// ft601_rx_buffer
// Elastic buffer on the FT601 read path. Captures words while a read is in
// progress, stores them in a FWFT FIFO and raises back-pressure early enough
// that words still in the FT601 read pipeline have room to land.
//
// Ports:
//   clk, rst           FT601 CLKOUT domain; synchronous active-high reset
//   usb_data_in        FT601 data bus
//   be_in              FT601 byte enables
//   usb_rden_l         RD_N from the controller
//   usb_rx_empty       RXF_N from the FT601
//   flush              synchronous clear of buffered words
//   out_data           head word
//   out_valid          buffer not empty
//   out_ready          downstream accepts the head word
//   lycan_in_full      registered back-pressure into the controller
//   level              current occupancy
//   partial_drop_cnt   saturating count of words with partial byte enables
//   overflow_drop_cnt  saturating count of words lost to a full buffer
//   overflow_sticky    set on the first overflow, cleared only by rst
// ----------------------------------------------------------------------------
module ft601_rx_buffer
  import ft601_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FT601_DATA_W-1:0]   usb_data_in,
  input  logic [FT601_BE_W-1:0]     be_in,
  input  logic                      usb_rden_l,
  input  logic                      usb_rx_empty,
  input  logic                      flush,
  output logic [FT601_DATA_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      lycan_in_full,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          partial_drop_cnt,
  output logic [CNT_W-1:0]          overflow_drop_cnt,
  output logic                      overflow_sticky
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          cap, cap_full_word;
  logic          pop, push, part_drop, ovf_drop;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] level_next;

  logic             bp_q, bp_d;
  logic [CNT_W-1:0] part_cnt_q, part_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             sticky_q, sticky_d;

  assign cap           = !usb_rden_l && !usb_rx_empty;
  assign cap_full_word = cap && (be_in == BE_ALL);
  assign pop           = out_valid && out_ready;

  // A word captured during flush is discarded silently: it is neither stored
  // nor counted as a drop.
  assign push      = cap_full_word && !flush && (!fifo_full || pop);
  assign part_drop = cap && (be_in != BE_ALL) && !flush;
  assign ovf_drop  = cap_full_word && !flush && fifo_full && !pop;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .W     (FT601_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .wr_en      (push),
    .wr_data    (usb_data_in),
    .rd_en      (out_ready),
    .rd_data    (out_data),
    .level      (level),
    .level_next (level_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  always_comb begin
    part_cnt_d = part_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    sticky_d   = sticky_q || ovf_drop;
    // Threshold on the next level so the flag is registered yet still leaves
    // MARGIN free entries for words already in flight from the FT601.
    bp_d       = flush || (level_next >= LW'(DEPTH - MARGIN));
    if (part_drop && (part_cnt_q != '1)) part_cnt_d = part_cnt_q + CNT_W'(1);
    if (ovf_drop  && (ovf_cnt_q  != '1)) ovf_cnt_d  = ovf_cnt_q  + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q       <= 1'b0;
      part_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      bp_q       <= bp_d;
      part_cnt_q <= part_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign lycan_in_full     = bp_q;
  assign partial_drop_cnt  = part_cnt_q;
  assign overflow_drop_cnt = ovf_cnt_q;
  assign overflow_sticky   = sticky_q;

  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (rst)
    pop |-> out_valid);

  a_head_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_ft601_rx_buffer.sv
// ----------------------------------------------------------------------------
// tb_ft601_rx_buffer
// Directed bench for ft601_rx_buffer (DEPTH=16, MARGIN=3). Stored words are
// pushed to a scoreboard queue when driven and compared against out_data when
// the bench expects the head to be consumed. Occupancy, back-pressure and the
// statistics are tracked by a small reference model and checked every cycle.
// ----------------------------------------------------------------------------
module tb_ft601_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 3;
  localparam int CNT_W  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] usb_data_in;
  logic [3:0]  be_in;
  logic        usb_rden_l;
  logic        usb_rx_empty;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        lycan_in_full;
  logic [4:0]  level;
  logic [15:0] partial_drop_cnt;
  logic [15:0] overflow_drop_cnt;
  logic        overflow_sticky;

  always #5 clk = ~clk;

  ft601_rx_buffer #(
    .DEPTH  (DEPTH),
    .MARGIN (MARGIN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .usb_data_in       (usb_data_in),
    .be_in             (be_in),
    .usb_rden_l        (usb_rden_l),
    .usb_rx_empty      (usb_rx_empty),
    .flush             (flush),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .lycan_in_full     (lycan_in_full),
    .level             (level),
    .partial_drop_cnt  (partial_drop_cnt),
    .overflow_drop_cnt (overflow_drop_cnt),
    .overflow_sticky   (overflow_sticky)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  int          m_level  = 0;
  int          m_pdrop  = 0;
  int          m_odrop  = 0;
  bit          m_sticky = 1'b0;
  bit          m_flushed = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle (entered just after a falling edge), compare the head
  // word if it is expected to be consumed, update the model, then check the
  // registered state just after the next falling edge.
  task automatic cycle(input bit c, input logic [3:0] be, input logic [31:0] d,
                       input bit rdy, input bit fl);
    bit pop_exp;
    usb_rden_l   = !c;
    usb_rx_empty = !c;
    be_in        = be;
    usb_data_in  = d;
    out_ready    = rdy;
    flush        = fl;
    #2;
    pop_exp = (m_level != 0) && rdy;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_level != 0});
    if (pop_exp) begin
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else                check("pop_data", {32'd0, out_data}, {32'd0, sb.pop_front()});
    end
    if (fl) begin
      sb.delete();
      m_level = 0;
    end else begin
      if (c) begin
        if (be != 4'hF) begin
          if (m_pdrop < 65535) m_pdrop++;
        end else if (m_level < DEPTH || pop_exp) begin
          sb.push_back(d);
          m_level++;
        end else begin
          if (m_odrop < 65535) m_odrop++;
          m_sticky = 1'b1;
        end
      end
      if (pop_exp) m_level--;
    end
    @(posedge clk);
    @(negedge clk);
    check("level", {59'd0, level}, 64'(m_level));
    check("lycan_in_full", {63'd0, lycan_in_full},
          {63'd0, (fl || m_level >= DEPTH - MARGIN)});
    check("partial_drop_cnt", {48'd0, partial_drop_cnt}, 64'(m_pdrop));
    check("overflow_drop_cnt", {48'd0, overflow_drop_cnt}, 64'(m_odrop));
    check("overflow_sticky", {63'd0, overflow_sticky}, {63'd0, m_sticky});
  endtask

  initial begin
    rst          = 1'b1;
    usb_data_in  = '0;
    be_in        = 4'hF;
    usb_rden_l   = 1'b1;
    usb_rx_empty = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_level", {59'd0, level}, 64'd0);
    check("rst_lycan_in_full", {63'd0, lycan_in_full}, 64'd0);
    check("rst_pdrop", {48'd0, partial_drop_cnt}, 64'd0);
    check("rst_odrop", {48'd0, overflow_drop_cnt}, 64'd0);
    check("rst_sticky", {63'd0, overflow_sticky}, 64'd0);

    // Five words streamed through with the downstream always ready.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'hF, 32'h1111_1111 * i, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    check("drain_level", {59'd0, level}, 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Fill to the back-pressure threshold with the downstream stalled.
    for (int i = 1; i <= 12; i++) cycle(1'b1, 4'hF, 32'hA000_0000 + i, 1'b0, 1'b0);
    check("bp_low_at_12", {63'd0, lycan_in_full}, 64'd0);
    cycle(1'b1, 4'hF, 32'hA000_000D, 1'b0, 1'b0);
    check("bp_high_at_13", {63'd0, lycan_in_full}, 64'd1);
    check("level_13", {59'd0, level}, 64'd13);

    // Five more: three fit, two overflow.
    for (int i = 14; i <= 18; i++) cycle(1'b1, 4'hF, 32'hA000_0000 + i, 1'b0, 1'b0);
    check("level_16", {59'd0, level}, 64'd16);
    check("odrop_2", {48'd0, overflow_drop_cnt}, 64'd2);
    check("sticky_set", {63'd0, overflow_sticky}, 64'd1);

    // Full buffer with simultaneous capture and pop: no drops, level holds.
    for (int i = 19; i <= 22; i++) cycle(1'b1, 4'hF, 32'hA000_0000 + i, 1'b1, 1'b0);
    check("level_full_hold", {59'd0, level}, 64'd16);
    check("odrop_still_2", {48'd0, overflow_drop_cnt}, 64'd2);

    // Drain: words 5..16 then 19..22 in order.
    repeat (18) cycle(1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    check("drain2_level", {59'd0, level}, 64'd0);
    check("drain2_sb_empty", 64'(sb.size()), 64'd0);

    // Partial byte enables are discarded and counted.
    cycle(1'b1, 4'h3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle(1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    check("pdrop_1", {48'd0, partial_drop_cnt}, 64'd1);
    check("partial_not_stored", {63'd0, out_valid}, 64'd0);

    // Level 7, then flush with a simultaneous capture.
    for (int i = 1; i <= 7; i++) cycle(1'b1, 4'hF, 32'hC000_0000 + i, 1'b0, 1'b0);
    check("level_7", {59'd0, level}, 64'd7);
    cycle(1'b1, 4'hF, 32'hBAD0_BAD0, 1'b0, 1'b1);
    check("flush_level", {59'd0, level}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_pdrop", {48'd0, partial_drop_cnt}, 64'd1);
    check("flush_odrop", {48'd0, overflow_drop_cnt}, 64'd2);
    check("flush_sticky", {63'd0, overflow_sticky}, 64'd1);
    repeat (3) cycle(1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    check("flush_nothing_delivered", {63'd0, out_valid}, 64'd0);

    // Reset mid-transfer clears everything, including the statistics.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'hF, 32'hE000_0000 + i, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_level  = 0;
    m_pdrop  = 0;
    m_odrop  = 0;
    m_sticky = 1'b0;
    check("rst2_level", {59'd0, level}, 64'd0);
    check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst2_odrop", {48'd0, overflow_drop_cnt}, 64'd0);
    check("rst2_sticky", {63'd0, overflow_sticky}, 64'd0);
    cycle(1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
    cycle(1'b0, 4'hF, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft601_rx_buffer.md
Name: ft601_rx_buffer

Overview:
- Receive-side elastic buffer directly downstream of the FT601 controller's read path.
- Captures 32-bit words from the FT601 data bus while a read is in progress and holds them in a small FIFO, so that words the FT601 presents after back-pressure is raised are not lost.
- Presents the stored words to the peripheral-side (lycan_in) FIFO through a first-word-fall-through valid/ready interface.
- Drives the lycan_in_full back-pressure signal into the controller, and keeps drop and overflow statistics for debug.

Parameters:
- DEPTH, 16: buffer entries; power of two, at least 4.
- MARGIN, 3: free entries that remain when lycan_in_full asserts; covers the FT601 read pipeline after RD_N deasserts.
- CNT_W, 16: width of the drop counters.

Ports:
- clk  in  1  system clock; the FT601 CLKOUT domain.
- rst  in  1  reset; synchronous, active-high.
- usb_data_in  in  32  FT601 data bus, sampled as input.
- be_in  in  4  FT601 byte enables.
- usb_rden_l  in  1  RD_N as driven by the controller.
- usb_rx_empty  in  1  RXF_N status from the FT601.
- flush  in  1  synchronous clear of buffer contents; statistics are kept.
- out_data  out  32  head word.
- out_valid  out  1  buffer not empty.
- out_ready  in  1  downstream accepts the word (inverse of the downstream FIFO's full flag).
- lycan_in_full  out  1  back-pressure to the controller.
- level  out  $clog2(DEPTH)+1  current occupancy.
- partial_drop_cnt  out  CNT_W  words dropped because byte enables were not all ones.
- overflow_drop_cnt  out  CNT_W  words dropped because the buffer was full.
- overflow_sticky  out  1  set on the first overflow; cleared only by rst.

Behaviour:
- Reset values: all pointers and the level are 0; out_valid=0; out_data=0; lycan_in_full=0; both counters are 0; overflow_sticky=0.
- Capture condition: cap = !usb_rden_l && !usb_rx_empty, evaluated every clk edge.
- cap with be_in==4'hF and a push allowed: the word is written at the write pointer.
- cap with be_in!=4'hF: the word is discarded and partial_drop_cnt increments.
- Push allowed when level<DEPTH, or when level==DEPTH with a pop in the same cycle.
- cap with full words and the push not allowed: the word is discarded, overflow_drop_cnt increments, and overflow_sticky sets.
- Pop: happens when out_valid && out_ready; the read pointer advances.
- Outputs: out_valid = (level!=0); out_data shows the head entry, fall-through and registered-memory based. There is no bypass: a word pushed into an empty buffer appears on out_valid one cycle after capture.
- Simultaneous push and pop: level is unchanged. At level==DEPTH this still holds and no drop occurs. At level==0 a pop cannot occur, since out_valid=0.
- Pointers: log2(DEPTH) bits each, wrapping naturally. level is a separate counter updated by +1 (push only), -1 (pop only) or 0 (both or neither).
- Back-pressure: lycan_in_full is a registered value, = (next level >= DEPTH-MARGIN). It also asserts when flush is high.
- Counters: saturate at all ones and do not wrap.
- flush: on the next edge the pointers and level go to 0 and out_valid falls. Any word captured in that same cycle is discarded and not counted. Counters and overflow_sticky are unaffected.
- rst mid-transfer: all state is cleared on the next edge and captured words are lost. The controller is reset by the same rst, so no handshake is needed.
- Assertions:
  - level never exceeds DEPTH;
  - no pop while out_valid=0;
  - out_data is stable while out_valid && !out_ready.

Decomposition:
- Shared package ft601_pkg holds:
  - FT601_DATA_W=32 and FT601_BE_W=4;
  - BE_ALL constant 4'hF;
  - the state_t enum already used by the controller, moved here so both blocks and the top level share it.
- Natural sub-module: sync_fifo_fwft, a generic DEPTH x W storage with pointers and level.
- ft601_rx_buffer wraps sync_fifo_fwft and adds the capture qualification, back-pressure threshold, drop counters and flush.

Test Plan:
- Reset, then 5 full words (0x11111111..0x55555555) captured with out_ready=1 -> out_valid rises 1 cycle after the first capture; 5 pops in order; level returns to 0; both counters remain 0.
- out_ready=0, 13 full words (DEPTH=16, MARGIN=3) -> lycan_in_full asserts on the edge after the 13th capture; level=13.
- Continue: 5 more words with out_ready=0 -> words 14-16 are stored; words 17-18 are dropped; overflow_drop_cnt=2; overflow_sticky=1; the popped sequence matches words 1-16.
- level=16 with cap and out_ready both high for 4 cycles -> no drops; level stays 16; output order is preserved.
- Word 0xDEADBEEF with be_in=4'h3 -> not stored; partial_drop_cnt=1.
- level=7, then flush for one cycle with a simultaneous cap -> level=0 and out_valid=0 on the next edge; counters unchanged; the captured word is not delivered.
